// File: rtl/branch_resolve_ctrl_pkg.sv
// branch_resolve_ctrl_pkg: shared queue entry struct, controller state enum and default queue depth/width constants
package branch_resolve_ctrl_pkg;
  localparam int BRQ_DEPTH = 4;
  localparam int BR_DATA_W = 32;
  typedef struct packed {
    logic [BR_DATA_W-1:0] pc;
    logic                 pred_taken;
    logic [BR_DATA_W-1:0] pred_target;
    logic                 cond;
  } br_entry_t;
  typedef enum logic {RUN, RECOVER} brc_state_e;
endpackage

// File: rtl/br_fifo.sv
// br_fifo: DEPTH-entry in-order queue of br_entry_t; ports clk, rst, push/din, pop/dout, flush, full, empty
module br_fifo
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  br_entry_t din,
  input  logic      pop,
  input  logic      flush,
  output br_entry_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] head, tail;
  br_entry_t mem [DEPTH];
  always_comb begin
    empty = head == tail;
    full = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);
    dout = mem[head[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push && !full) tail <= tail + 1'b1;
      if (pop && !empty) head <= head + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !full) mem[tail[AW-1:0]] <= din;
  end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: in-order branch queue between IF/EX with table updates, mispredict redirect/flush; IF enq_*, EX res_*, upd_*, redirect_*, q_empty, err_underflow, optional stat_* under BRANCH_STATS_EN
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DEPTH  = BRQ_DEPTH,
  parameter int DATA_W = BR_DATA_W,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [DATA_W-1:0] enq_pc,
  input  logic              enq_pred_taken,
  input  logic [DATA_W-1:0] enq_pred_target,
  input  logic              enq_cond,
  input  logic              res_valid,
  input  logic              res_taken,
  input  logic [DATA_W-1:0] res_target,
  output logic              upd_valid,
  output logic [IDX_W-1:0]  upd_idx,
  output logic              upd_taken,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              q_empty,
  output logic              err_underflow
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_resolved,
  output logic [31:0]       stat_mispredict
`endif
);
  brc_state_e state_q, state_d;
  br_entry_t entry, head;
  logic full, empty, push, pop, mispredict;
  logic [DATA_W-1:0] correct_pc;
  br_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(entry), .pop(pop),
    .flush(mispredict), .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk) state_q <= rst ? RUN : state_d;
  always_comb state_d = (state_q == RUN && mispredict) ? RECOVER : RUN;
  always_comb begin
    enq_ready = !full && state_q == RUN;
    q_empty = empty;
    entry = '{pc: enq_pc, pred_taken: enq_pred_taken, pred_target: enq_pred_target, cond: enq_cond};
    pop = res_valid && !empty && state_q == RUN;
    mispredict = pop && (head.pred_taken != res_taken || (res_taken && head.pred_target != res_target));
    push = enq_valid && enq_ready && !mispredict;
    correct_pc = res_taken ? res_target : head.pc + DATA_W'(4);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid <= 1'b0;
      upd_idx <= '0;
      upd_taken <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      err_underflow <= 1'b0;
    end else begin
      upd_valid <= pop && head.cond;
      redirect_valid <= mispredict;
      err_underflow <= err_underflow || (res_valid && !pop);
      if (pop) begin
        upd_idx <= head.pc[IDX_W+1:2];
        upd_taken <= res_taken;
      end
      if (mispredict) redirect_pc <= correct_pc;
    end
  end
`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved <= '0;
      stat_mispredict <= '0;
    end else begin
      if (pop && stat_resolved != '1) stat_resolved <= stat_resolved + 1'b1;
      if (mispredict && stat_mispredict != '1) stat_mispredict <= stat_mispredict + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed and random checks of branch_resolve_ctrl against a queue-based reference model
module tb_branch_resolve_ctrl;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1;
  logic enq_valid = 0, enq_pred_taken = 0, enq_cond = 0, res_valid = 0, res_taken = 0;
  logic [31:0] enq_pc = 0, enq_pred_target = 0, res_target = 0;
  logic enq_ready, upd_valid, upd_taken, redirect_valid, q_empty, err_underflow;
  logic [9:0] upd_idx;
  logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_resolved, stat_mispredict;
  int m_res = 0, m_mis = 0;
`endif
  branch_resolve_ctrl dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
    .enq_pred_taken(enq_pred_taken), .enq_pred_target(enq_pred_target), .enq_cond(enq_cond),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .q_empty(q_empty),
    .err_underflow(err_underflow)
`ifdef BRANCH_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] pc; logic pt; logic [31:0] tg; logic c;} ent_t;
  ent_t q[$];
  logic recov = 0, m_err = 0;
  int n = 0, errs = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic ev, input logic [31:0] pc, input logic pt,
                     input logic [31:0] ptg, input logic c, input logic rv, input logic rt,
                     input logic [31:0] rtg);
    logic rdy, pop, mis, e_upd, e_ut, e_red;
    logic [31:0] e_rpc, hpc;
    logic [9:0] e_idx;
    ent_t h, e;
    rst = r; enq_valid = ev; enq_pc = pc; enq_pred_taken = pt; enq_pred_target = ptg;
    enq_cond = c; res_valid = rv; res_taken = rt; res_target = rtg;
    #1;
    rdy = q.size() < DEPTH && !recov;
    if (!r) begin
      chk("enq_ready", enq_ready, rdy);
      chk("q_empty", q_empty, q.size() == 0);
    end
    pop = rv && q.size() > 0 && !recov;
    mis = 0; e_upd = 0; e_red = 0; e_ut = 0; e_idx = 0; e_rpc = 0;
    if (rv && !pop) m_err = 1;
    if (pop) begin
      h = q.pop_front();
      mis = (h.pt != rt) || (h.pt && rt && h.tg != rtg);
      e_upd = h.c;
      hpc = h.pc;
      e_idx = hpc[11:2];
      e_ut = rt;
      e_red = mis;
      e_rpc = rt ? rtg : h.pc + 32'd4;
    end
    if (ev && rdy && !mis) begin
      e = '{pc: pc, pt: pt, tg: ptg, c: c};
      q.push_back(e);
    end
    if (mis) q.delete();
`ifdef BRANCH_STATS_EN
    if (pop) m_res++;
    if (mis) m_mis++;
`endif
    recov = mis;
    if (r) begin
      q.delete(); recov = 0; m_err = 0; e_upd = 0; e_red = 0;
`ifdef BRANCH_STATS_EN
      m_res = 0; m_mis = 0;
`endif
    end
    @(posedge clk); #1;
    chk("upd_valid", upd_valid, e_upd);
    chk("redirect_valid", redirect_valid, e_red);
    chk("err_underflow", err_underflow, m_err);
    if (e_upd) begin
      chk("upd_idx", upd_idx, e_idx);
      chk("upd_taken", upd_taken, e_ut);
    end
    if (e_red) chk("redirect_pc", redirect_pc, e_rpc);
    if (r) begin
      chk("rst_upd_idx", upd_idx, 0);
      chk("rst_upd_taken", upd_taken, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      chk("rst_q_empty", q_empty, 1);
    end
`ifdef BRANCH_STATS_EN
    chk("stat_resolved", stat_resolved, m_res);
    chk("stat_mispredict", stat_mispredict, m_mis);
`endif
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    logic [31:0] tg_set [4];
    tg_set = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h100, 0, 32'h0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    cyc(0, 1, 32'h200, 0, 32'h0, 1, 0, 0, 0);
    cyc(0, 1, 32'h204, 0, 32'h0, 1, 0, 0, 0);
    cyc(0, 1, 32'h208, 1, 32'h800, 1, 0, 0, 0);
    cyc(0, 1, 32'h20c, 0, 32'h0, 1, 1, 1, 32'h300);
    cyc(0, 1, 32'h300, 0, 32'h0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h400, 1, 32'h500, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 32'h504);
    idle();
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'h600 + 32'(i * 4), 0, 32'h0, 1, 0, 0, 0);
    cyc(0, 1, 32'h700, 0, 32'h0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'hFFFFFFFC, 1, 32'h40, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    cyc(0, 1, 32'h900, 0, 32'h0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 32'hA00);
    idle();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 32'hB00 + 32'(i * 4), 0, 32'h0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, (i == 1 || i == 3), 32'hC00);
    end
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(199) == 0, $urandom_range(1) == 1, $urandom & 32'hFFFFFFFC,
          $urandom_range(1) == 1, tg_set[$urandom_range(3)], $urandom_range(1) == 1,
          $urandom_range(2) == 0, $urandom_range(1) == 1, tg_set[$urandom_range(3)]);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
